// File: rtl/scr1_memif_pkg.sv
// rtl/scr1_memif_pkg.sv - shared memory-interface typedefs and dmem router constants
package scr1_memif_pkg;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } type_scr1_dmem_router_fsm_e;

    localparam logic [1:0] SCR1_DMEM_SEL_PORT0 = 2'd0;
    localparam logic [1:0] SCR1_DMEM_SEL_PORT1 = 2'd1;
    localparam logic [1:0] SCR1_DMEM_SEL_PORT2 = 2'd2;

endpackage

// File: rtl/scr1_dmem_addr_decode.sv
// rtl/scr1_dmem_addr_decode.sv - combinational dmem address to target port select
module scr1_dmem_addr_decode
    import scr1_memif_pkg::*;
#(
    parameter logic [31:0] PORT1_ADDR_MASK    = 32'hFFFF_C000,
    parameter logic [31:0] PORT1_ADDR_PATTERN = 32'hF000_0000,
    parameter logic [31:0] PORT2_ADDR_MASK    = 32'hFFFF_FFE0,
    parameter logic [31:0] PORT2_ADDR_PATTERN = 32'hF004_0000
) (
    input  logic [31:0] addr_i,
    output logic [1:0]  sel_o
);

    // TCM wins over the timer window if the two ever overlap.
    always_comb begin
        if ((addr_i & PORT1_ADDR_MASK) == PORT1_ADDR_PATTERN) begin
            sel_o = SCR1_DMEM_SEL_PORT1;
        end else if ((addr_i & PORT2_ADDR_MASK) == PORT2_ADDR_PATTERN) begin
            sel_o = SCR1_DMEM_SEL_PORT2;
        end else begin
            sel_o = SCR1_DMEM_SEL_PORT0;
        end
    end

endmodule

// File: rtl/scr1_dmem_router.sv
// rtl/scr1_dmem_router.sv - single-outstanding LSU dmem router to bus/TCM/timer ports
// Optional response watchdog with DRAIN state: SCR1_DMEM_ROUTER_TIMEOUT_EN
module scr1_dmem_router
    import scr1_memif_pkg::*;
#(
    parameter logic [31:0] PORT1_ADDR_MASK    = 32'hFFFF_C000,
    parameter logic [31:0] PORT1_ADDR_PATTERN = 32'hF000_0000,
    parameter logic [31:0] PORT2_ADDR_MASK    = 32'hFFFF_FFE0,
    parameter logic [31:0] PORT2_ADDR_PATTERN = 32'hF004_0000
`ifdef SCR1_DMEM_ROUTER_TIMEOUT_EN
   ,parameter int          TIMEOUT_CYCLES     = 255
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dmem_req_i,
    input  logic        dmem_cmd_i,
    input  logic [1:0]  dmem_width_i,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_wdata_i,
    output logic        dmem_req_ack_o,
    output logic [31:0] dmem_rdata_o,
    output logic [1:0]  dmem_resp_o,
    output logic        port0_req_o,
    output logic        port0_cmd_o,
    output logic [1:0]  port0_width_o,
    output logic [31:0] port0_addr_o,
    output logic [31:0] port0_wdata_o,
    input  logic        port0_req_ack_i,
    input  logic [31:0] port0_rdata_i,
    input  logic [1:0]  port0_resp_i,
    output logic        port1_req_o,
    output logic        port1_cmd_o,
    output logic [1:0]  port1_width_o,
    output logic [31:0] port1_addr_o,
    output logic [31:0] port1_wdata_o,
    input  logic        port1_req_ack_i,
    input  logic [31:0] port1_rdata_i,
    input  logic [1:0]  port1_resp_i,
    output logic        port2_req_o,
    output logic        port2_cmd_o,
    output logic [1:0]  port2_width_o,
    output logic [31:0] port2_addr_o,
    output logic [31:0] port2_wdata_o,
    input  logic        port2_req_ack_i,
    input  logic [31:0] port2_rdata_i,
    input  logic [1:0]  port2_resp_i
);

    type_scr1_dmem_router_fsm_e state_q, state_d;
    logic [1:0]  port_sel_q, port_sel_d;
    logic [1:0]  sel;
    logic        sel_ack;
    logic [1:0]  tgt_resp;
    logic [31:0] tgt_rdata;
    logic        resp_vld;
    logic        resp_done;
    logic        fwd_en;
    logic        req_accept;
    logic        timeout_hit;

    scr1_dmem_addr_decode #(
        .PORT1_ADDR_MASK    (PORT1_ADDR_MASK),
        .PORT1_ADDR_PATTERN (PORT1_ADDR_PATTERN),
        .PORT2_ADDR_MASK    (PORT2_ADDR_MASK),
        .PORT2_ADDR_PATTERN (PORT2_ADDR_PATTERN)
    ) u_addr_decode (
        .addr_i (dmem_addr_i),
        .sel_o  (sel)
    );

    // Request-side ack follows the live decode; response side follows the captured port.
    always_comb begin
        case (sel)
            SCR1_DMEM_SEL_PORT1: sel_ack = port1_req_ack_i;
            SCR1_DMEM_SEL_PORT2: sel_ack = port2_req_ack_i;
            default:             sel_ack = port0_req_ack_i;
        endcase
        case (port_sel_q)
            SCR1_DMEM_SEL_PORT1: begin tgt_resp = port1_resp_i; tgt_rdata = port1_rdata_i; end
            SCR1_DMEM_SEL_PORT2: begin tgt_resp = port2_resp_i; tgt_rdata = port2_rdata_i; end
            default:             begin tgt_resp = port0_resp_i; tgt_rdata = port0_rdata_i; end
        endcase
    end

    assign resp_vld   = (tgt_resp == SCR1_MEM_RESP_RDY_OK) || (tgt_resp == SCR1_MEM_RESP_RDY_ER);
    assign resp_done  = (state_q == WAIT) && resp_vld;
    assign req_accept = dmem_req_i & fwd_en & sel_ack;

`ifdef SCR1_DMEM_ROUTER_TIMEOUT_EN
    logic [15:0] wdog_cnt_q, wdog_cnt_d;

    // A response on the expiry cycle takes precedence over the timeout.
    assign timeout_hit = (state_q == WAIT) && !resp_vld && (wdog_cnt_q == 16'(TIMEOUT_CYCLES));

    always_comb begin
        wdog_cnt_d = wdog_cnt_q;
        if (req_accept) begin
            wdog_cnt_d = '0;
        end else if ((state_q == WAIT) && !resp_vld && !timeout_hit) begin
            wdog_cnt_d = wdog_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt_q <= '0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            port_sel_q <= SCR1_DMEM_SEL_PORT0;
        end else begin
            state_q    <= state_d;
            port_sel_q <= port_sel_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        port_sel_d = port_sel_q;
        case (state_q)
            IDLE: begin
                if (req_accept) begin
                    state_d    = WAIT;
                    port_sel_d = sel;
                end
            end
            WAIT: begin
                if (resp_done) begin
                    if (req_accept) begin
                        port_sel_d = sel;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (timeout_hit) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (resp_vld) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fwd_en       = 1'b0;
        dmem_resp_o  = SCR1_MEM_RESP_NOTRDY;
        dmem_rdata_o = '0;
        case (state_q)
            IDLE: fwd_en = 1'b1;
            WAIT: begin
                fwd_en = resp_done;
                if (timeout_hit) begin
                    dmem_resp_o = SCR1_MEM_RESP_RDY_ER;
                end else begin
                    dmem_resp_o  = tgt_resp;
                    dmem_rdata_o = tgt_rdata;
                end
            end
            default: ;
        endcase
    end

    assign dmem_req_ack_o = fwd_en & sel_ack;

    assign port0_req_o   = dmem_req_i & fwd_en & (sel == SCR1_DMEM_SEL_PORT0);
    assign port1_req_o   = dmem_req_i & fwd_en & (sel == SCR1_DMEM_SEL_PORT1);
    assign port2_req_o   = dmem_req_i & fwd_en & (sel == SCR1_DMEM_SEL_PORT2);

    assign port0_cmd_o   = dmem_cmd_i;
    assign port1_cmd_o   = dmem_cmd_i;
    assign port2_cmd_o   = dmem_cmd_i;
    assign port0_width_o = dmem_width_i;
    assign port1_width_o = dmem_width_i;
    assign port2_width_o = dmem_width_i;
    assign port0_addr_o  = dmem_addr_i;
    assign port1_addr_o  = dmem_addr_i;
    assign port2_addr_o  = dmem_addr_i;
    assign port0_wdata_o = dmem_wdata_i;
    assign port1_wdata_o = dmem_wdata_i;
    assign port2_wdata_o = dmem_wdata_i;

endmodule

// File: tb/tb_scr1_dmem_router.sv
// tb/tb_scr1_dmem_router.sv - scoreboard bench for scr1_dmem_router (SCR1_DMEM_ROUTER_TIMEOUT_EN adds watchdog case)
module tb_scr1_dmem_router;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dmem_req, dmem_cmd, dmem_req_ack;
    logic [1:0]  dmem_width, dmem_resp;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        p0_req, p0_cmd, p0_ack, p1_req, p1_cmd, p1_ack, p2_req, p2_cmd, p2_ack;
    logic [1:0]  p0_width, p0_resp, p1_width, p1_resp, p2_width, p2_resp;
    logic [31:0] p0_addr, p0_wdata, p0_rdata, p1_addr, p1_wdata, p1_rdata, p2_addr, p2_wdata, p2_rdata;

    int          vectors = 0;
    int          miscompares = 0;
    logic [33:0] exp_q[$];

    always #5 clk = ~clk;

    scr1_dmem_router #(
`ifdef SCR1_DMEM_ROUTER_TIMEOUT_EN
        .TIMEOUT_CYCLES (8)
`else
        .PORT1_ADDR_MASK (32'hFFFF_C000)
`endif
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .dmem_req_i (dmem_req), .dmem_cmd_i (dmem_cmd), .dmem_width_i (dmem_width),
        .dmem_addr_i (dmem_addr), .dmem_wdata_i (dmem_wdata), .dmem_req_ack_o (dmem_req_ack),
        .dmem_rdata_o (dmem_rdata), .dmem_resp_o (dmem_resp),
        .port0_req_o (p0_req), .port0_cmd_o (p0_cmd), .port0_width_o (p0_width),
        .port0_addr_o (p0_addr), .port0_wdata_o (p0_wdata), .port0_req_ack_i (p0_ack),
        .port0_rdata_i (p0_rdata), .port0_resp_i (p0_resp),
        .port1_req_o (p1_req), .port1_cmd_o (p1_cmd), .port1_width_o (p1_width),
        .port1_addr_o (p1_addr), .port1_wdata_o (p1_wdata), .port1_req_ack_i (p1_ack),
        .port1_rdata_i (p1_rdata), .port1_resp_i (p1_resp),
        .port2_req_o (p2_req), .port2_cmd_o (p2_cmd), .port2_width_o (p2_width),
        .port2_addr_o (p2_addr), .port2_wdata_o (p2_wdata), .port2_req_ack_i (p2_ack),
        .port2_rdata_i (p2_rdata), .port2_resp_i (p2_resp)
    );

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Monitor: every non-idle response must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [33:0] e;
        if (rst_n === 1'b1 && dmem_resp !== 2'b00) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_resp: got resp %b rdata %h, expected no response", dmem_resp, dmem_rdata);
            end else begin
                e = exp_q.pop_front();
                if ({dmem_resp, dmem_rdata} !== e) begin
                    miscompares++;
                    $display("FAIL resp_rdata: got %b/%h, expected %b/%h", dmem_resp, dmem_rdata, e[33:32], e[31:0]);
                end
            end
        end
    end

    logic [31:0] dec_addr [6] = '{32'hF000_3FFC, 32'hF000_4000, 32'hF004_001F,
                                  32'hF004_0020, 32'hEFFF_FFFF, 32'hF004_0000};
    logic [2:0]  dec_exp  [6] = '{3'b010, 3'b001, 3'b100, 3'b001, 3'b001, 3'b100};

    initial begin
        rst_n = 1'b0;
        dmem_req = 0; dmem_cmd = 0; dmem_width = 2'b10; dmem_addr = '0; dmem_wdata = '0;
        p0_ack = 0; p0_resp = 0; p0_rdata = '0;
        p1_ack = 0; p1_resp = 0; p1_rdata = '0;
        p2_ack = 0; p2_resp = 0; p2_rdata = '0;

        smp();
        chk("rst_resp", {32'b0, dmem_resp}, 34'd0);
        chk("rst_reqs", {31'b0, p2_req, p1_req, p0_req}, 34'd0);
        chk1("rst_ack", dmem_req_ack, 1'b0);
        cyc(); cyc();
        rst_n = 1'b1;

        // Address decode boundaries, no acks so nothing is accepted.
        for (int i = 0; i < 6; i++) begin
            dmem_req = 1; dmem_addr = dec_addr[i];
            smp();
            chk($sformatf("decode_%0d", i), {31'b0, p2_req, p1_req, p0_req}, {31'b0, dec_exp[i]});
            cyc();
        end
        dmem_req = 0;
        cyc();

        // 1: TCM read, immediate ack, response next cycle.
        dmem_req = 1; dmem_cmd = 0; dmem_addr = 32'hF000_0010; p1_ack = 1;
        smp();
        chk1("t1_p1_req", p1_req, 1'b1);
        chk1("t1_ack", dmem_req_ack, 1'b1);
        chk("t1_p1_addr", {2'b0, p1_addr}, {2'b0, 32'hF000_0010});
        cyc();
        dmem_req = 0; p1_ack = 0; p1_resp = 2'b01; p1_rdata = 32'hCAFE_0001;
        exp_q.push_back({2'b01, 32'hCAFE_0001});
        smp();
        chk1("t1_p1_req_drop", p1_req, 1'b0);
        cyc();
        p1_resp = 0; p1_rdata = '0;

        // 2: bus write with ack held off for 3 cycles.
        dmem_req = 1; dmem_cmd = 1; dmem_addr = 32'h8000_0000; dmem_wdata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk1($sformatf("t2_ack_low_%0d", i), dmem_req_ack, 1'b0);
            chk("t2_reqs", {31'b0, p2_req, p1_req, p0_req}, 34'b001);
            cyc();
        end
        p0_ack = 1;
        smp();
        chk1("t2_ack_high", dmem_req_ack, 1'b1);
        chk("t2_reqs_ack", {31'b0, p2_req, p1_req, p0_req}, 34'b001);
        chk("t2_wdata", {1'b0, p0_cmd, p0_wdata}, {2'b01, 32'h1234_5678});
        cyc();
        dmem_req = 0; dmem_cmd = 0; p0_ack = 0; p0_resp = 2'b01;
        exp_q.push_back({2'b01, 32'h0});
        cyc();
        p0_resp = 0;

        // 3: timer read returns error, then FSM is idle.
        dmem_req = 1; dmem_addr = 32'hF004_0008; p2_ack = 1;
        smp();
        chk("t3_reqs", {31'b0, p2_req, p1_req, p0_req}, 34'b100);
        cyc();
        dmem_req = 0; p2_ack = 0; p2_resp = 2'b10; p2_rdata = 32'hDEAD_BEEF;
        exp_q.push_back({2'b10, 32'hDEAD_BEEF});
        cyc();
        smp();
        chk("t3_idle_resp", {32'b0, dmem_resp}, 34'd0);
        cyc();
        p2_resp = 0; p2_rdata = '0;

        // 4: back-to-back request forwarded in the response cycle.
        dmem_req = 1; dmem_addr = 32'hF000_0000; p1_ack = 1;
        smp();
        chk1("t4_ack_first", dmem_req_ack, 1'b1);
        cyc();
        p1_ack = 0; p1_resp = 2'b01; p1_rdata = 32'h1111_2222;
        exp_q.push_back({2'b01, 32'h1111_2222});
        dmem_addr = 32'hF004_0000; p2_ack = 1;
        smp();
        chk("t4_reqs_b2b", {31'b0, p2_req, p1_req, p0_req}, 34'b100);
        chk1("t4_ack_b2b", dmem_req_ack, 1'b1);
        cyc();
        dmem_req = 0; p2_ack = 0; p1_rdata = 32'h5555_5555;
        smp();
        chk("t4_stale_p1", {32'b0, dmem_resp}, 34'd0);
        cyc();
        p1_resp = 0; p1_rdata = '0; p2_resp = 2'b01; p2_rdata = 32'h3333_4444;
        exp_q.push_back({2'b01, 32'h3333_4444});
        cyc();
        p2_resp = 0; p2_rdata = '0;

        // 5: reset while waiting, stale response ignored, next request routed.
        dmem_req = 1; dmem_addr = 32'h8000_0004; p0_ack = 1;
        cyc();
        dmem_req = 0; p0_ack = 0;
        rst_n = 1'b0;
        smp();
        chk("t5_rst_resp", {32'b0, dmem_resp}, 34'd0);
        cyc();
        p0_resp = 2'b01; p0_rdata = 32'h9999_0000;
        cyc();
        rst_n = 1'b1;
        smp();
        chk("t5_stale_resp", {32'b0, dmem_resp}, 34'd0);
        cyc();
        p0_resp = 0; p0_rdata = '0;
        dmem_req = 1; dmem_addr = 32'hF000_0100; p1_ack = 1;
        smp();
        chk("t5_reqs", {31'b0, p2_req, p1_req, p0_req}, 34'b010);
        cyc();
        dmem_req = 0; p1_ack = 0; p1_resp = 2'b01; p1_rdata = 32'hABCD_0005;
        exp_q.push_back({2'b01, 32'hABCD_0005});
        cyc();
        p1_resp = 0; p1_rdata = '0;

`ifdef SCR1_DMEM_ROUTER_TIMEOUT_EN
        // 6: silent port0 times out, late response swallowed in DRAIN.
        dmem_req = 1; dmem_addr = 32'h8000_0000; p0_ack = 1;
        cyc();
        dmem_req = 0; p0_ack = 0;
        for (int i = 0; i < 8; i++) begin
            smp();
            chk($sformatf("t6_silent_%0d", i), {32'b0, dmem_resp}, 34'd0);
            cyc();
        end
        exp_q.push_back({2'b10, 32'h0});
        cyc();
        dmem_req = 1; dmem_addr = 32'hF000_0000; p1_ack = 1;
        smp();
        chk1("t6_drain_p1_req", p1_req, 1'b0);
        chk1("t6_drain_ack", dmem_req_ack, 1'b0);
        cyc();
        p0_resp = 2'b01; p0_rdata = 32'h0000_0077;
        smp();
        chk("t6_late_resp", {32'b0, dmem_resp}, 34'd0);
        chk1("t6_late_p1_req", p1_req, 1'b0);
        cyc();
        p0_resp = 0; p0_rdata = '0;
        smp();
        chk1("t6_idle_p1_req", p1_req, 1'b1);
        chk1("t6_idle_ack", dmem_req_ack, 1'b1);
        cyc();
        dmem_req = 0; p1_ack = 0; p1_resp = 2'b01; p1_rdata = 32'h0000_0006;
        exp_q.push_back({2'b01, 32'h0000_0006});
        cyc();
        p1_resp = 0; p1_rdata = '0;
`endif

        cyc(); cyc();
        chk("resp_queue_empty", 34'(exp_q.size()), 34'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
